// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (MSB of each word first) and writes the
// assembled 32-bit words into instruction memory, stalling the CPU meanwhile.
// Optional feature macro: IMEM_CHECKSUM_EN adds a running modulo-2^32 sum of
// written words on the checksum output; without it checksum is tied to zero.
module imem_loader #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        cpu_stall,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [32:0] MEM_WORDS_C = 33'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic        byte_ready_q, byte_ready_d;
    logic        im_we_q, im_we_d;
    logic [31:0] im_addr_q, im_addr_d;
    logic [31:0] im_wdata_q, im_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [32:0] span_s;
    logic        illegal_s;
    logic [16:0] index_inc_s;
    logic        xfer_s;
    logic        start_acc_s;

    // Range/alignment check of a requested load (33-bit sum so nothing wraps)
    always_comb begin
        span_s    = {3'b000, base_addr[31:2]} + {17'd0, word_count};
        illegal_s = (base_addr[1:0] != 2'b00) || (span_s > MEM_WORDS_C);
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        index_d     = index_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        err_d       = err_q;
        start_acc_s = 1'b0;
        xfer_s      = byte_ready_q && byte_valid;
        index_inc_s = {1'b0, index_q} + 17'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    base_d      = base_addr;
                    count_d     = word_count;
                    index_d     = 16'd0;
                    bcnt_d      = 2'd0;
                    word_d      = 24'd0;
                    if (illegal_s) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (word_count == 16'd0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RECV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (xfer_s) begin
                    word_d = {word_q[15:0], byte_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        im_addr_d  = base_q + {14'd0, index_q, 2'b00};
                        im_wdata_d = {word_q, byte_data};
                        state_d    = S_WRITE;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end
            S_WRITE: begin
                index_d = index_inc_s[15:0];
                if (index_inc_s == {1'b0, count_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        byte_ready_d = (state_d == S_RECV);
        im_we_d      = (state_d == S_WRITE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= 32'd0;
            count_q      <= 16'd0;
            index_q      <= 16'd0;
            bcnt_q       <= 2'd0;
            word_q       <= 24'd0;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            im_addr_q    <= 32'd0;
            im_wdata_q   <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            index_q      <= index_d;
            bcnt_q       <= bcnt_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Running sum: cleared on a sampled start, accumulates each written word
    always_comb begin
        checksum_d = checksum_q;
        if (start_acc_s) begin
            checksum_d = 32'd0;
        end else if (state_q == S_WRITE) begin
            checksum_d = checksum_q + im_wdata_q;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= 32'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
    assign checksum           = 32'd0;
`endif

    assign byte_ready = byte_ready_q;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign busy       = busy_q;
    assign cpu_stall  = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// checked against a word-level reference model (expected writes, err, timing).
module tb_imem_loader;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        cpu_stall;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          done_cnt = 0;
    int          br_cnt   = 0;

    imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .cpu_stall  (cpu_stall),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Log memory writes, done pulses and byte_ready cycles mid-cycle
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_wdata);
        end
        if (done === 1'b1) done_cnt++;
        if (byte_ready === 1'b1) br_cnt++;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        br_cnt   = 0;
    endtask

    // One complete load: drives start and the byte stream, then checks the result
    task automatic do_load(input logic [31:0] base, input logic [31:0] words[$],
                           input int mode, input bit inject);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        logic [31:0] sum;
        logic [31:0] exp_sum;
        bit          legal;
        bit          seen;
        bit          xfer;
        int          cnt;
        int          nb;
        int          bi;
        int          cyc;
        int          budget;
        cnt = words.size();
        for (int j = 0; j < cnt; j++) begin
            w = words[j];
            for (int k = 0; k < 4; k++) bytes.push_back(w[31-8*k -: 8]);
        end
        nb     = bytes.size();
        legal  = (base % 4 == 0) && (longint'(base >> 2) + longint'(cnt) <= longint'(MEM_WORDS));
        budget = 20 * cnt + 40;

        @(posedge clk); #1;
        clear_log();
        start      = 1'b1;
        base_addr  = base;
        word_count = 16'(cnt);
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        bi = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            check32("cpu_stall_eq_busy", 32'(cpu_stall), 32'(busy));
            if (done === 1'b1) seen = 1'b1;
            xfer = (byte_valid === 1'b1) && (byte_ready === 1'b1);
            @(posedge clk); #1;
            if (inject && cyc == 6) begin
                start      = 1'b1;
                base_addr  = 32'h0000_0000;
                word_count = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (xfer) bi++;
            if (bi < nb) begin
                case (mode)
                    0:       byte_valid = 1'b1;
                    1:       byte_valid = cyc[0];
                    default: byte_valid = 1'($urandom_range(0, 1));
                endcase
                byte_data = bytes[bi];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        check32("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);

        check32("done_pulses", 32'(done_cnt), 32'd1);
        check32("err", 32'(err), 32'(!legal));
        check32("busy_idle", 32'(busy), 32'd0);
        check32("bytes_consumed", 32'(bi), legal ? 32'(nb) : 32'd0);
        sum = 32'd0;
        if (legal) begin
            check32("write_count", 32'(wa_q.size()), 32'(cnt));
            for (int j = 0; j < cnt && j < wa_q.size(); j++) begin
                check32("write_addr", wa_q[j], base + 32'(4 * j));
                check32("write_data", wd_q[j], words[j]);
                sum = sum + words[j];
            end
            if (cnt > 0) begin
                check32("hold_addr", im_addr, base + 32'(4 * (cnt - 1)));
                check32("hold_data", im_wdata, words[cnt-1]);
            end else begin
                check32("no_ready_cnt0", 32'(br_cnt), 32'd0);
            end
        end else begin
            check32("write_count_rej", 32'(wa_q.size()), 32'd0);
            check32("no_ready_rej", 32'(br_cnt), 32'd0);
        end
        if (mode == 0 && !inject) begin
            check32("load_cycles", 32'(cyc), (legal && cnt > 0) ? 32'(5 * cnt + 2) : 32'd2);
        end
`ifdef IMEM_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = 32'd0;
`endif
        check32("checksum", checksum, exp_sum);
    endtask

    logic [31:0] wl[$];
    logic [31:0] rbase;
    int          rcnt;
    int          rsel;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = 32'd0;
        word_count = 16'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;

        // Reset state
        @(negedge clk);
        check32("rst_byte_ready", 32'(byte_ready), 32'd0);
        check32("rst_im_we", 32'(im_we), 32'd0);
        check32("rst_im_addr", im_addr, 32'd0);
        check32("rst_im_wdata", im_wdata, 32'd0);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        check32("rst_checksum", checksum, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two-word directed program
        wl = '{32'h2008_0005, 32'h8C09_0004};
        do_load(32'h0000_0028, wl, 0, 1'b0);
`ifdef IMEM_CHECKSUM_EN
        check32("checksum_const", checksum, 32'hAC11_0009);
`endif

        // Zero-length load
        wl.delete();
        do_load(32'h0000_0100, wl, 0, 1'b0);

        // Rejected loads: misaligned, past the end, wrapping address
        wl = '{32'h1111_1111, 32'h2222_2222};
        do_load(32'h0000_0002, wl, 0, 1'b0);
        do_load(32'h0000_03FC, wl, 0, 1'b0);
        wl = '{32'h3333_3333};
        do_load(32'hFFFF_FFFC, wl, 0, 1'b0);

        // Exactly filling the last two words is legal and clears err
        wl = '{$urandom, $urandom};
        do_load(32'h0000_03F8, wl, 0, 1'b0);

        // Toggling byte_valid with an ignored mid-load start
        wl = '{$urandom};
        do_load(32'h0000_0010, wl, 1, 1'b1);

        // Randomized loads
        for (int t = 0; t < 12; t++) begin
            rsel = $urandom_range(0, 3);
            rcnt = $urandom_range(0, 5);
            case (rsel)
                1:       rbase = 32'($urandom_range(248, 256)) << 2;
                2:       rbase = (32'($urandom_range(0, 200)) << 2) | 32'($urandom_range(1, 3));
                default: rbase = 32'($urandom_range(0, 250)) << 2;
            endcase
            wl.delete();
            for (int j = 0; j < rcnt; j++) wl.push_back($urandom);
            do_load(rbase, wl, $urandom_range(0, 2), 1'b0);
        end

        // Reset after two bytes of a word discards the partial word
        @(posedge clk); #1;
        clear_log();
        start      = 1'b1;
        base_addr  = 32'h0000_0040;
        word_count = 16'd1;
        @(posedge clk); #1;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        @(posedge clk); #1;
        byte_data  = 8'hBB;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        check32("midrst_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        check32("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check32("midrst_im_we", 32'(im_we), 32'd0);
        check32("midrst_im_addr", im_addr, 32'd0);
        check32("midrst_im_wdata", im_wdata, 32'd0);
        check32("midrst_busy", 32'(busy), 32'd0);
        check32("midrst_cpu_stall", 32'(cpu_stall), 32'd0);
        check32("midrst_done", 32'(done), 32'd0);
        check32("midrst_err", 32'(err), 32'd0);
        check32("midrst_checksum", checksum, 32'd0);
        check32("midrst_no_write", 32'(wa_q.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wl = '{$urandom};
        do_load(32'h0000_0044, wl, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
